// File: rtl/screen_layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
// Shared types and constants for the game-screen layer sequencer and the VGA
// object priority mux:
//   screen_state_t : 2-bit screen encoding (START=0, PLAY=1, WIN=2, LOSE=3)
//   LYR_*          : bit index of each drawing layer inside the 16-bit mask
//   MASK_*         : per-screen layer enable masks (WIN without confetti)
//   pend_t         : sticky event flags captured between frame starts
// -----------------------------------------------------------------------------
package screen_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_WIN   = 2'd2,
      ST_LOSE  = 2'd3
   } screen_state_t;

   localparam int NUM_LAYERS = 16;
   typedef logic [NUM_LAYERS-1:0] layer_mask_t;

   // Seventeen named layers share sixteen mask bits. The two portals are only
   // ever enabled together (PLAY screen only), so they share one bit and the
   // masks behave exactly as if each portal had its own.
   localparam int LYR_SIGHT      = 0;
   localparam int LYR_WHITE      = 1;
   localparam int LYR_BALL1      = 2;
   localparam int LYR_BALL2      = 3;
   localparam int LYR_BALL3      = 4;
   localparam int LYR_BALL4      = 5;
   localparam int LYR_NUMBER     = 6;
   localparam int LYR_TARGET     = 7;
   localparam int LYR_POINTS     = 8;
   localparam int LYR_HOLE       = 9;
   localparam int LYR_PORTAL_O   = 10;
   localparam int LYR_PORTAL_B   = 10;
   localparam int LYR_START      = 11;
   localparam int LYR_WIN        = 12;
   localparam int LYR_LOSE       = 13;
   localparam int LYR_CONFETTI   = 14;
   localparam int LYR_BACKGROUND = 15;

   function automatic layer_mask_t layer_bit(input int idx);
      layer_mask_t m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

   localparam layer_mask_t MASK_START = layer_bit(LYR_BACKGROUND) | layer_bit(LYR_START);

   localparam layer_mask_t MASK_PLAY =
      layer_bit(LYR_SIGHT)    | layer_bit(LYR_WHITE)    |
      layer_bit(LYR_BALL1)    | layer_bit(LYR_BALL2)    |
      layer_bit(LYR_BALL3)    | layer_bit(LYR_BALL4)    |
      layer_bit(LYR_NUMBER)   | layer_bit(LYR_TARGET)   |
      layer_bit(LYR_POINTS)   | layer_bit(LYR_HOLE)     |
      layer_bit(LYR_PORTAL_O) | layer_bit(LYR_PORTAL_B) |
      layer_bit(LYR_BACKGROUND);

   localparam layer_mask_t MASK_WIN =
      layer_bit(LYR_WIN) | layer_bit(LYR_POINTS) | layer_bit(LYR_BACKGROUND);

   localparam layer_mask_t MASK_LOSE =
      layer_bit(LYR_LOSE) | layer_bit(LYR_POINTS) | layer_bit(LYR_BACKGROUND);

   typedef struct packed {
      logic start;
      logic win;
      logic lose;
   } pend_t;

endpackage

// File: rtl/screen_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// screen_layer_sequencer_if
// Bundle between the game-logic event sources / mux and the sequencer.
//   startOfFrame : 1-cycle pulse at first pixel of each frame
//   startKey     : start request from the key decoder (level or pulse)
//   winEvent     : 1-cycle pulse, all target balls sunk
//   loseEvent    : 1-cycle pulse, white ball sunk or shots exhausted
//   layerEn      : registered per-layer enable mask
//   gameActive   : high while in PLAY
//   screenDone   : 1-cycle pulse when a WIN/LOSE hold expires
//   screenState  : current screen encoding
// master = event/frame source side, slave = sequencer.
// -----------------------------------------------------------------------------
interface screen_layer_sequencer_if;
   import screen_pkg::*;

   logic          startOfFrame;
   logic          startKey;
   logic          winEvent;
   logic          loseEvent;
   layer_mask_t   layerEn;
   logic          gameActive;
   logic          screenDone;
   screen_state_t screenState;

   modport master (
      output startOfFrame, startKey, winEvent, loseEvent,
      input  layerEn, gameActive, screenDone, screenState
   );

   modport slave (
      input  startOfFrame, startKey, winEvent, loseEvent,
      output layerEn, gameActive, screenDone, screenState
   );
endinterface

// File: rtl/screen_layer_sequencer_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Frame counter used for the end-screen hold and the confetti blink.
//   clk, reset : clock, async active-high reset
//   clr_i      : synchronous clear, dominates tick_i
//   tick_i     : advance by one (once per frame)
//   last_i     : terminal count; the counter wraps to 0 after it
//   tc_o       : tick_i while the count equals last_i (combinational)
// -----------------------------------------------------------------------------
module frame_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             tick_i,
   input  logic [CNT_W-1:0] last_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   // tc_o deliberately ignores clr_i: the parent derives clr_i from a next
   // state that itself depends on tc_o.
   assign tc_o = tick_i & (cnt_q == last_i);

   // NOTE: every signal assigned in always_comb gets a default at the top so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = (cnt_q == last_i) ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value, independent of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/screen_layer_sequencer.sv
// -----------------------------------------------------------------------------
// screen_layer_sequencer
// Frame-synchronous screen controller: START -> PLAY -> WIN/LOSE -> START.
// Drives the layer enable mask for the object priority mux; mask and state
// only change on the edge that samples startOfFrame, so a frame never mixes
// two screens.
//   clk, reset : pixel clock, async active-high reset
//   seq        : slave side of screen_layer_sequencer_if (events in,
//                layerEn/gameActive/screenDone/screenState out)
// -----------------------------------------------------------------------------
module screen_layer_sequencer
   import screen_pkg::*;
#(
   parameter int WIN_FRAMES   = 180,
   parameter int LOSE_FRAMES  = 120,
   parameter int BLINK_FRAMES = 8,
   parameter int CNT_W        = 8
) (
   input logic                     clk,
   input logic                     reset,
   screen_layer_sequencer_if.slave seq
);

   localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_FRAMES - 1);
   localparam logic [CNT_W-1:0] LOSE_LAST  = CNT_W'(LOSE_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

   screen_state_t state_d, state_q;
   pend_t         pend_d, pend_q;
   logic          confetti_on_d, confetti_on_q;
   layer_mask_t   layer_en_d, layer_en_q;
   logic          game_active_d, game_active_q;
   logic          screen_done_d, screen_done_q;

   logic             sof;
   pend_t            evt, pend_all;
   logic             in_end_q, in_end_d;
   logic             hold_clr, hold_tc;
   logic             blink_clr, blink_tc;
   logic [CNT_W-1:0] hold_last;

   assign sof = seq.startOfFrame;

   // Events of the current cycle join the evaluation, so an event coinciding
   // with startOfFrame is not lost.
   assign evt      = '{start: seq.startKey, win: seq.winEvent, lose: seq.loseEvent};
   assign pend_all = pend_t'(pend_q | evt);

   assign in_end_q = (state_q == ST_WIN) || (state_q == ST_LOSE);
   assign in_end_d = (state_d == ST_WIN) || (state_d == ST_LOSE);

   // Clearing on entry and on exit keeps each counter at 0 outside its screen
   // and starts it from 0 on the frame the screen appears.
   assign hold_clr  = !in_end_q || !in_end_d;
   assign blink_clr = (state_q != ST_WIN) || (state_d != ST_WIN);
   assign hold_last = (state_q == ST_WIN) ? WIN_LAST : LOSE_LAST;

   frame_timer #(.CNT_W(CNT_W)) u_hold_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (hold_clr),
      .tick_i (sof),
      .last_i (hold_last),
      .tc_o   (hold_tc)
   );

   frame_timer #(.CNT_W(CNT_W)) u_blink_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (blink_clr),
      .tick_i (sof),
      .last_i (BLINK_LAST),
      .tc_o   (blink_tc)
   );

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      screen_done_d = 1'b0;
      confetti_on_d = confetti_on_q;
      layer_en_d    = layer_en_q;
      game_active_d = game_active_q;

      if (sof) begin
         // Every flag is consumed or dropped at the frame boundary.
         pend_d = '0;
         unique case (state_q)
            ST_START: if (pend_all.start) state_d = ST_PLAY;
            ST_PLAY: begin
               if (pend_all.win)       state_d = ST_WIN;
               else if (pend_all.lose) state_d = ST_LOSE;
            end
            ST_WIN, ST_LOSE: begin
               if (hold_tc) begin
                  state_d       = ST_START;
                  screen_done_d = 1'b1;
               end
            end
            default: state_d = ST_START;
         endcase
      end else begin
         // End screens ignore all events, so nothing is captured there.
         pend_d = in_end_q ? pend_t'('0) : pend_all;
      end

      if (state_d != ST_WIN)                     confetti_on_d = 1'b1;
      else if ((state_q == ST_WIN) && blink_tc)  confetti_on_d = ~confetti_on_q;

      // Mask and gameActive follow the next state so they switch on the same
      // edge as screenState.
      unique case (state_d)
         ST_START: layer_en_d = MASK_START;
         ST_PLAY:  layer_en_d = MASK_PLAY;
         ST_WIN:   layer_en_d = MASK_WIN | (confetti_on_d ? layer_bit(LYR_CONFETTI) : '0);
         ST_LOSE:  layer_en_d = MASK_LOSE;
         default:  layer_en_d = MASK_START;
      endcase
      game_active_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_START;
         pend_q        <= '0;
         confetti_on_q <= 1'b1;
         layer_en_q    <= MASK_START;
         game_active_q <= 1'b0;
         screen_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         confetti_on_q <= confetti_on_d;
         layer_en_q    <= layer_en_d;
         game_active_q <= game_active_d;
         screen_done_q <= screen_done_d;
      end
   end

   assign seq.layerEn     = layer_en_q;
   assign seq.gameActive  = game_active_q;
   assign seq.screenDone  = screen_done_q;
   assign seq.screenState = state_q;

endmodule
